// File: rtl/spi_pkg.sv
// Shared constants and the enable decode for the SPI baud generator.
package spi_pkg;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
  localparam logic [1:0] SPI_MODE_STOP = 2'b10;

  localparam int SPI_BRD_W   = 12;
  localparam int SPI_BRD_MIN = 2;
  localparam int SPI_BRD_MAX = 2048;

  // Clocking runs only with slave selected and the core not parked in a low-power mode.
  function automatic logic spi_enable(input logic       ss_n,
                                      input logic [1:0] mode,
                                      input logic       swai);
    return !ss_n && ((mode == SPI_MODE_RUN) || ((mode == SPI_MODE_WAIT) && !swai));
  endfunction

endpackage

// File: rtl/spi_baud_divisor_calc.sv
// Registers the baud divisor (sppr+1) << (spr+1); resets to the minimum divisor.
module spi_baud_divisor_calc #(
  parameter int BRD_W  = 12,
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  output logic [BRD_W-1:0]  BaudRateDivisor
);
  import spi_pkg::*;

  logic [BRD_W-1:0] brd_d, brd_q;

  // Shift amount widened by one bit so spr=7 still yields a shift of 8.
  always_comb begin
    brd_d = (BRD_W'(sppr) + BRD_W'(1)) << ((SPR_W+1)'(spr) + (SPR_W+1)'(1));
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) brd_q <= BRD_W'(SPI_BRD_MIN);
    else        brd_q <= brd_d;
  end

  assign BaudRateDivisor = brd_q;

endmodule

// File: rtl/spi_baud_generator.sv
// SPI sclk and shift/sample strobe generator, all four CPOL/CPHA modes.
// Optional SPI_BAUD_EDGE_CNT_EN adds edge_cnt and xfer_done outputs.
module spi_baud_generator #(
  parameter int BRD_W  = 12,
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [1:0]        spi_mode,
  input  logic              spiswai,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  output logic              sclk,
  output logic              miso_receive_sclk,
  output logic              mosi_send_sclk,
`ifdef SPI_BAUD_EDGE_CNT_EN
  output logic [BRD_W-1:0]  BaudRateDivisor,
  output logic [4:0]        edge_cnt,
  output logic              xfer_done
`else
  output logic [BRD_W-1:0]  BaudRateDivisor
`endif
);
  import spi_pkg::*;

  logic             en, sclk_edge, lead_edge, trail_edge;
  logic             en_d, en_q;
  logic [BRD_W-1:0] div_d, div_q, cnt_d, cnt_q;
  logic             sclk_d, sclk_q, lead_d, lead_q;
  logic             miso_d, miso_q, mosi_d, mosi_q;

  spi_baud_divisor_calc #(
    .BRD_W (BRD_W),
    .SPPR_W(SPPR_W),
    .SPR_W (SPR_W)
  ) u_div_calc (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .sppr           (sppr),
    .spr            (spr),
    .BaudRateDivisor(BaudRateDivisor)
  );

  // lead_q=0 means the next sclk edge moves away from the idle level.
  always_comb begin
    en         = spi_enable(ss, spi_mode, spiswai);
    sclk_edge  = en && (cnt_q == div_q - BRD_W'(1));
    lead_edge  = sclk_edge && !lead_q;
    trail_edge = sclk_edge && lead_q;
    en_d       = en;
    div_d      = (en && !en_q) ? BaudRateDivisor : div_q;
    cnt_d      = '0;
    sclk_d     = cpol;
    lead_d     = 1'b0;
    miso_d     = 1'b0;
    mosi_d     = 1'b0;
    if (en) begin
      cnt_d  = sclk_edge ? '0 : cnt_q + BRD_W'(1);
      sclk_d = sclk_edge ? !sclk_q : sclk_q;
      lead_d = sclk_edge ? !lead_q : lead_q;
      miso_d = cpha ? trail_edge : lead_edge;
      mosi_d = cpha ? lead_edge : trail_edge;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en_q   <= 1'b0;
      div_q  <= BRD_W'(SPI_BRD_MIN);
      cnt_q  <= '0;
      sclk_q <= cpol;
      lead_q <= 1'b0;
      miso_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      lead_q <= lead_d;
      miso_q <= miso_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk              = sclk_q;
  assign miso_receive_sclk = miso_q;
  assign mosi_send_sclk    = mosi_q;

`ifdef SPI_BAUD_EDGE_CNT_EN
  localparam logic [4:0] EDGE_SAT = 5'd16;

  logic [4:0] edge_cnt_d, edge_cnt_q;
  logic       xfer_d, xfer_q;

  // Saturating edge count; xfer_done marks the 16th edge of a byte.
  always_comb begin
    edge_cnt_d = '0;
    xfer_d     = 1'b0;
    if (en) begin
      edge_cnt_d = (sclk_edge && (edge_cnt_q != EDGE_SAT)) ? edge_cnt_q + 5'd1 : edge_cnt_q;
      xfer_d     = sclk_edge && (edge_cnt_q == EDGE_SAT - 5'd1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      edge_cnt_q <= '0;
      xfer_q     <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      xfer_q     <= xfer_d;
    end
  end

  assign edge_cnt  = edge_cnt_q;
  assign xfer_done = xfer_q;
`endif

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed bench for spi_baud_generator; sclk/strobe expectations come from a cycle model.
module tb_spi_baud_generator;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [1:0]  spi_mode = 2'b00;
  logic        spiswai = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        ss = 1'b1;
  logic [2:0]  sppr = 3'd0;
  logic [2:0]  spr = 3'd0;
  logic        sclk, miso_receive_sclk, mosi_send_sclk;
  logic [11:0] BaudRateDivisor;
`ifdef SPI_BAUD_EDGE_CNT_EN
  logic [4:0]  edge_cnt;
  logic        xfer_done;
`endif

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  spi_baud_generator dut (
    .PCLK             (PCLK),
    .PRESET           (PRESET),
    .spi_mode         (spi_mode),
    .spiswai          (spiswai),
    .cpol             (cpol),
    .cpha             (cpha),
    .ss               (ss),
    .sppr             (sppr),
    .spr              (spr),
    .sclk             (sclk),
    .miso_receive_sclk(miso_receive_sclk),
    .mosi_send_sclk   (mosi_send_sclk),
`ifdef SPI_BAUD_EDGE_CNT_EN
    .BaudRateDivisor  (BaudRateDivisor),
    .edge_cnt         (edge_cnt),
    .xfer_done        (xfer_done)
`else
    .BaudRateDivisor  (BaudRateDivisor)
`endif
  );

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  // Expected {sclk, miso, mosi} i cycles after the first enabled cycle was driven.
  function automatic logic [2:0] model(int i, int div, logic pol, logic pha);
    int   e;
    logic stb, lead;
    e    = i / div;
    stb  = ((i % div) == 0) && (e > 0);
    lead = (e % 2) == 1;
    return {pol ^ lead, stb && (pha ? !lead : lead), stb && (pha ? lead : !lead)};
  endfunction

  // Expected {xfer_done, edge_cnt}.
  function automatic logic [5:0] edge_model(int i, int div);
    int e;
    e = i / div;
    return {((i % div) == 0) && (e == 16), 5'((e > 16) ? 16 : e)};
  endfunction

  task automatic test_reset();
    PRESET = 1'b1; cpol = 1'b1; ss = 1'b1; sppr = 3'd5; spr = 3'd3;
    cyc();
    total++;
    if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b100 || BaudRateDivisor !== 12'd2) begin
      bad++;
      $display("FAIL reset_state got sclk/miso/mosi=%b brd=%0d want 100 brd=2",
               {sclk, miso_receive_sclk, mosi_send_sclk}, BaudRateDivisor);
    end
    PRESET = 1'b0; sppr = 3'd0; spr = 3'd0;
    cyc();
    total++;
    if (BaudRateDivisor !== 12'd2 || sclk !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got brd=%0d sclk=%b want brd=2 sclk=1", BaudRateDivisor, sclk);
    end
    cpol = 1'b0;
    cyc();
    total++;
    if (sclk !== 1'b0) begin
      bad++;
      $display("FAIL idle_cpol_follow got sclk=%b want 0", sclk);
    end
  endtask

  task automatic test_mode0();
    int nm, ns;
    logic [2:0] exp;
    sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; spi_mode = 2'b00; spiswai = 1'b0; ss = 1'b1;
    cyc();
    total++;
    if (BaudRateDivisor !== 12'd2) begin
      bad++;
      $display("FAIL mode0_brd got=%0d want=2", BaudRateDivisor);
    end
    ss = 1'b0; nm = 0; ns = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      exp = model(i, 2, 1'b0, 1'b0);
      nm += int'(miso_receive_sclk);
      ns += int'(mosi_send_sclk);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL mode0_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
`ifdef SPI_BAUD_EDGE_CNT_EN
      total++;
      if ({xfer_done, edge_cnt} !== edge_model(i, 2)) begin
        bad++;
        $display("FAIL mode0_edge%0d got=%b want=%b", i, {xfer_done, edge_cnt}, edge_model(i, 2));
      end
`endif
    end
    total++;
    if (nm !== 8 || ns !== 8) begin
      bad++;
      $display("FAIL mode0_pulse_count got miso=%0d mosi=%0d want 8 8", nm, ns);
    end
    ss = 1'b1;
    cyc();
  endtask

  task automatic test_mode3();
    logic [2:0] exp;
    sppr = 3'd2; spr = 3'd1; cpol = 1'b1; cpha = 1'b1;
    cyc();
    total++;
    if (BaudRateDivisor !== 12'd12 || sclk !== 1'b1) begin
      bad++;
      $display("FAIL mode3_idle got brd=%0d sclk=%b want brd=12 sclk=1", BaudRateDivisor, sclk);
    end
    ss = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      cyc();
      exp = model(i, 12, 1'b1, 1'b1);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL mode3_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
      if (i == 5) cpol = 1'b0;
    end
    ss = 1'b1;
    cyc();
    total++;
    if (sclk !== 1'b0) begin
      bad++;
      $display("FAIL mode3_cpol_after_idle got sclk=%b want 0", sclk);
    end
  endtask

  task automatic test_wait();
    logic [2:0] exp;
    sppr = 3'd1; spr = 3'd0; cpol = 1'b0; cpha = 1'b0;
    cyc();
    spi_mode = 2'b01; spiswai = 1'b1; ss = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b000) begin
        bad++;
        $display("FAIL wait_swai_cyc%0d got=%b want=000", i, {sclk, miso_receive_sclk, mosi_send_sclk});
      end
    end
    spiswai = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp = model(i, 4, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL wait_run_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
    end
    spi_mode = 2'b10;
    cyc();
    cyc();
    total++;
    if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b000) begin
      bad++;
      $display("FAIL stop_mode got=%b want=000", {sclk, miso_receive_sclk, mosi_send_sclk});
    end
    spi_mode = 2'b00; ss = 1'b1;
    cyc();
  endtask

  task automatic test_abort();
    logic [2:0] exp;
    ss = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp = model(i, 4, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL abort_pre_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
    end
    ss = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b000) begin
        bad++;
        $display("FAIL abort_idle_cyc%0d got=%b want=000", i, {sclk, miso_receive_sclk, mosi_send_sclk});
      end
    end
    ss = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp = model(i, 4, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL abort_restart_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
    end
    ss = 1'b1;
    cyc();
  endtask

  task automatic test_div_change();
    logic [2:0] exp;
    sppr = 3'd0; spr = 3'd0;
    cyc();
    ss = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      exp = model(i, 2, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL divchg_old_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
      if (i == 4) begin
        total++;
        if (BaudRateDivisor !== 12'd8) begin
          bad++;
          $display("FAIL divchg_brd got=%0d want=8", BaudRateDivisor);
        end
      end
      if (i == 3) spr = 3'd2;
    end
    ss = 1'b1;
    cyc();
    ss = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      exp = model(i, 8, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL divchg_new_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    ss = 1'b1; spr = 3'd0;
    cyc();
    total++;
    if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_gap got=%b want=000", {sclk, miso_receive_sclk, mosi_send_sclk});
    end
    ss = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp = model(i, 2, 1'b0, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL b2b_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
    end
    ss = 1'b1;
    cyc();
  endtask

  task automatic test_preset_mid();
    logic [2:0] exp;
    sppr = 3'd0; spr = 3'd0; cpol = 1'b1; cpha = 1'b0;
    cyc();
    ss = 1'b0;
    for (int i = 1; i <= 5; i++) cyc();
    PRESET = 1'b1; sppr = 3'd3;
    cyc();
    total++;
    if ({sclk, miso_receive_sclk, mosi_send_sclk} !== 3'b100 || BaudRateDivisor !== 12'd2) begin
      bad++;
      $display("FAIL preset_mid got sclk/miso/mosi=%b brd=%0d want 100 brd=2",
               {sclk, miso_receive_sclk, mosi_send_sclk}, BaudRateDivisor);
    end
`ifdef SPI_BAUD_EDGE_CNT_EN
    total++;
    if (edge_cnt !== 5'd0 || xfer_done !== 1'b0) begin
      bad++;
      $display("FAIL preset_edge got edge_cnt=%0d xfer=%b want 0 0", edge_cnt, xfer_done);
    end
`endif
    PRESET = 1'b0; sppr = 3'd0;
    for (int i = 1; i <= 34; i++) begin
      cyc();
      exp = model(i, 2, 1'b1, 1'b0);
      total++;
      if ({sclk, miso_receive_sclk, mosi_send_sclk} !== exp) begin
        bad++;
        $display("FAIL post_preset_cyc%0d got=%b want=%b", i, {sclk, miso_receive_sclk, mosi_send_sclk}, exp);
      end
`ifdef SPI_BAUD_EDGE_CNT_EN
      total++;
      if ({xfer_done, edge_cnt} !== edge_model(i, 2)) begin
        bad++;
        $display("FAIL post_preset_edge%0d got=%b want=%b", i, {xfer_done, edge_cnt}, edge_model(i, 2));
      end
`endif
    end
    ss = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_wait();
    test_abort();
    test_div_change();
    test_back_to_back();
    test_preset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
- Generates the SPI serial clock (sclk) and the per-bit shift/sample strobes for the APB SPI master core.
- Sits beside the slave-select control. It consumes that block's ss output and exports the BaudRateDivisor that the slave-select control uses to time a transfer.
- The downstream shift register uses its strobes to drive MOSI and capture MISO.
- Supports all four CPOL/CPHA modes and honours the run/wait/stop low-power modes.

Parameters:
- BRD_W, 12, width of BaudRateDivisor and the internal counter.
- SPPR_W, 3, width of the baud prescaler field.
- SPR_W, 3, width of the baud rate-select field.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- spi_mode  in  2  00 = run, 01 = wait, 10/11 = stop.
- spiswai  in  1  when 1, the SPI clock is stopped while in wait mode.
- cpol  in  1  sclk idle level.
- cpha  in  1  0 = sample on the leading edge; 1 = sample on the trailing edge.
- ss  in  1  active-low slave select from the slave-select control.
- sppr  in  SPPR_W  baud prescaler.
- spr  in  SPR_W  baud rate select.
- sclk  out  1  serial clock to the pad.
- miso_receive_sclk  out  1  one-cycle pulse: sample MISO now.
- mosi_send_sclk  out  1  one-cycle pulse: shift the next MOSI bit now.
- BaudRateDivisor  out  BRD_W  (sppr+1)*2^(spr+1).

Behaviour:
- Divisor:
  - BaudRateDivisor = (sppr+1) << (spr+1). Range is 2 (0,0) to 2048 (7,7); it never overflows 12 bits.
  - The output is registered: it is updated one PCLK cycle after sppr or spr change.
- Enable: en = !ss && (spi_mode==00 || (spi_mode==01 && !spiswai)). Stop mode, or wait mode with spiswai=1, gives en=0.
- Divisor latch:
  - An internal div_q captures BaudRateDivisor on the cycle en goes 0->1.
  - Changes to sppr or spr mid-transfer do not affect div_q until the next transfer.
- Counter cnt (BRD_W bits):
  - When en=0: cnt=0, sclk=cpol, both strobes=0, all taking effect on the next cycle.
  - When en=1: cnt increments each cycle. When cnt==div_q-1, cnt wraps to 0 and sclk toggles on that clock edge.
  - sclk half-period = div_q PCLK cycles; one sclk period = 2*div_q cycles; 8 bits = 16*div_q cycles.
- Edge phase register lead:
  - Cleared when en=0.
  - Toggles on each sclk edge. The first edge after enable is a leading edge (sclk moves away from cpol).
- Strobes (registered; high exactly one cycle, coinciding with the first PCLK cycle in which sclk shows its new level):
  - cpha=0: miso_receive_sclk on leading edges; mosi_send_sclk on trailing edges. Bit 0 is presented by the shift register at ss assertion.
  - cpha=1: mosi_send_sclk on leading edges; miso_receive_sclk on trailing edges.
  - The two strobes are never high in the same cycle.
- Timing: the first sclk edge occurs div_q cycles after the first cycle with en=1.
- Boundary conditions:
  - ss rising mid-bit: abort. Next cycle, sclk returns to cpol, cnt=0, no further strobes.
  - cpol change while idle: sclk follows on the next cycle. Change while en=1: ignored until idle.
  - en dropping and returning in back-to-back cycles: counts restart from 0 with a fresh div_q latch.
- Reset: PRESET=1 forces cnt=0, lead=0, sclk=cpol, miso_receive_sclk=0, mosi_send_sclk=0, BaudRateDivisor=2 (the sppr=0, spr=0 value), div_q=2. Reset takes priority over all other inputs, including mid-transfer.

Optional Feature:
- SPI_BAUD_EDGE_CNT_EN defined:
  - Adds output edge_cnt[4:0], counting sclk edges since en rose and saturating at 16.
  - Cleared by reset and when en=0.
  - Also adds output xfer_done, a one-cycle pulse when edge_cnt reaches 16.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package spi_pkg holds:
  - Constants SPI_MODE_RUN=2'b00, SPI_MODE_WAIT=2'b01, SPI_MODE_STOP=2'b10.
  - BRD_W=12 and the min/max divisor constants (2, 2048).
  - The enable-decode function.
- One sub-module, spi_baud_divisor_calc: registers (sppr+1)<<(spr+1) into BaudRateDivisor. The top instantiates it and adds the counter, sclk and strobe logic.

Test Plan:
- sppr=0, spr=0, cpol=0, cpha=0, run mode, ss low at t0:
  - BaudRateDivisor=2; sclk toggles every 2 PCLK cycles with the first rise 2 cycles after en.
  - 16 edges in 32 cycles; 8 miso_receive_sclk pulses on rises; 8 mosi_send_sclk pulses on falls.
- sppr=2, spr=1, cpol=1, cpha=1: BaudRateDivisor=12; sclk idles high; half-period is 12 cycles; mosi_send_sclk on falling (leading) edges, miso_receive_sclk on rising edges.
- Wait mode with spiswai=1 and ss low: sclk stays at cpol, no strobes, cnt=0. Setting spiswai=0 starts clocking with the first edge div_q cycles later.
- ss deasserted after 5 sclk edges with BRD=4: next cycle sclk=cpol, no further strobes. Re-asserting ss restarts with the first edge 4 cycles later.
- Change spr from 0 to 2 mid-transfer: sclk period stays 2*2 until ss rises. The next transfer uses half-period 8, and BaudRateDivisor reads 8 one cycle after the change.
- PRESET asserted mid-transfer with cpol=1: next cycle sclk=1, both strobes=0, BaudRateDivisor=2. With SPI_BAUD_EDGE_CNT_EN: edge_cnt=0, and an uninterrupted transfer with BRD=2 shows xfer_done after 32 cycles.
